// File: rtl/rob_complete_arb.sv
// Completion arbiter: per-unit one-entry holding slots, round-robin pick, registered ROB port.
// Optional CMPL_ARB_PERF_EN adds a saturating contention counter (conflict_cnt).
module rob_complete_arb #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ROB_IDX_BITS  = 4,
  parameter int unsigned PHYS_REG_BITS = 6,
  localparam int unsigned SrcW         = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ROB_IDX_BITS-1:0]   req_idx,
  input  logic [NUM_REQ*PHYS_REG_BITS-1:0]  req_phys_rd,
  input  logic [NUM_REQ*32-1:0]             req_result,
  output logic                              complete_en,
  output logic [ROB_IDX_BITS-1:0]           complete_idx,
  output logic [31:0]                       complete_result,
  output logic [PHYS_REG_BITS-1:0]          wake_phys_rd,
  output logic [SrcW-1:0]                   grant_src
`ifdef CMPL_ARB_PERF_EN
  ,
  output logic [15:0]                       conflict_cnt
`endif
);

  logic [NUM_REQ-1:0]       hold_valid_q;
  logic [ROB_IDX_BITS-1:0]  hold_idx_q    [NUM_REQ];
  logic [PHYS_REG_BITS-1:0] hold_phys_q   [NUM_REQ];
  logic [31:0]              hold_result_q [NUM_REQ];
  logic [SrcW-1:0]          rr_ptr_q;

  logic                     cmpl_en_q;
  logic [ROB_IDX_BITS-1:0]  cmpl_idx_q;
  logic [31:0]              cmpl_result_q;
  logic [PHYS_REG_BITS-1:0] wake_q;
  logic [SrcW-1:0]          src_q;

  logic [NUM_REQ-1:0]       grant;
  logic                     grant_any;
  logic [SrcW-1:0]          grant_sel;
  logic [SrcW-1:0]          scan;
  logic [SrcW-1:0]          rr_ptr_next;
  logic [NUM_REQ-1:0]       accept;

  // Round-robin scan over held slots only, starting at rr_ptr_q and wrapping.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_sel = '0;
    scan      = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && hold_valid_q[scan]) begin
        grant_any = 1'b1;
        grant_sel = scan;
      end
      scan = (scan == SrcW'(NUM_REQ - 1)) ? '0 : scan + SrcW'(1);
    end
    if (grant_any) grant[grant_sel] = 1'b1;
  end

  assign rr_ptr_next = (grant_sel == SrcW'(NUM_REQ - 1)) ? '0 : grant_sel + SrcW'(1);

  // Granted slot drains this edge, so it can take a new entry back-to-back.
  assign req_ready = (rst || flush) ? '0 : (~hold_valid_q | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q  <= '0;
      rr_ptr_q      <= '0;
      cmpl_en_q     <= 1'b0;
      cmpl_idx_q    <= '0;
      cmpl_result_q <= '0;
      wake_q        <= '0;
      src_q         <= '0;
    end else if (flush) begin
      hold_valid_q <= '0;
      cmpl_en_q    <= 1'b0;
    end else begin
      hold_valid_q <= accept | (hold_valid_q & ~grant);
      cmpl_en_q    <= grant_any;
      if (grant_any) begin
        cmpl_idx_q    <= hold_idx_q[grant_sel];
        cmpl_result_q <= hold_result_q[grant_sel];
        wake_q        <= hold_phys_q[grant_sel];
        src_q         <= grant_sel;
        rr_ptr_q      <= rr_ptr_next;
      end
    end
  end

  // Payload only; validity is tracked by hold_valid_q.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_idx_q[i]    <= req_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS];
        hold_phys_q[i]   <= req_phys_rd[i*PHYS_REG_BITS +: PHYS_REG_BITS];
        hold_result_q[i] <= req_result[i*32 +: 32];
      end
    end
  end

  assign complete_en     = cmpl_en_q;
  assign complete_idx    = cmpl_idx_q;
  assign complete_result = cmpl_result_q;
  assign wake_phys_rd    = wake_q;
  assign grant_src       = src_q;

`ifdef CMPL_ARB_PERF_EN
  logic [15:0] conflict_q;

  // Counts grants made while another slot was left waiting; flush cycles do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (!flush && grant_any && (|(hold_valid_q & ~grant)) &&
                 (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_rob_complete_arb.sv
// Bench for rob_complete_arb: directed vector table plus randomized run against a slot model.
// Perf-counter checks are compiled in when CMPL_ARB_PERF_EN is defined.
module tb_rob_complete_arb;
  localparam int N  = 3;
  localparam int IW = 4;
  localparam int PW = 6;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*IW-1:0] req_idx;
  logic [N*PW-1:0] req_phys_rd;
  logic [N*32-1:0] req_result;
  logic            complete_en;
  logic [IW-1:0]   complete_idx;
  logic [31:0]     complete_result;
  logic [PW-1:0]   wake_phys_rd;
  logic [SW-1:0]   grant_src;
`ifdef CMPL_ARB_PERF_EN
  logic [15:0]     conflict_cnt;
`endif

  rob_complete_arb #(
    .NUM_REQ      (N),
    .ROB_IDX_BITS (IW),
    .PHYS_REG_BITS(PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_idx        (req_idx),
    .req_phys_rd    (req_phys_rd),
    .req_result     (req_result),
    .complete_en    (complete_en),
    .complete_idx   (complete_idx),
    .complete_result(complete_result),
    .wake_phys_rd   (wake_phys_rd),
    .grant_src      (grant_src)
`ifdef CMPL_ARB_PERF_EN
    ,
    .conflict_cnt   (conflict_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of occupied slots, a pointer, and the last completion.
  bit          m_v    [N];
  int          m_idx  [N];
  int          m_phys [N];
  logic [31:0] m_res  [N];
  int          m_ptr  = 0;
  bit          m_en   = 0;
  int          m_oidx = 0, m_ophys = 0, m_src = 0;
  logic [31:0] m_ores = '0;
  int          m_cnt  = 0;
  int          m_win;
  logic [N-1:0] m_rdy, rdy_smp;

  task automatic model_pre();
    m_win = -1;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (m_win < 0 && m_v[s]) m_win = s;
    end
    for (int i = 0; i < N; i++) m_rdy[i] = !rst && !flush && (!m_v[i] || m_win == i);
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_ptr = 0; m_en = 0; m_oidx = 0; m_ophys = 0; m_src = 0; m_ores = '0; m_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_en = 0;
    end else begin
      if (m_win >= 0) begin
        int others;
        others = 0;
        for (int i = 0; i < N; i++) if (i != m_win && m_v[i]) others++;
        if (others > 0 && m_cnt < 65535) m_cnt++;
        m_en = 1; m_oidx = m_idx[m_win]; m_ophys = m_phys[m_win];
        m_ores = m_res[m_win]; m_src = m_win;
        m_v[m_win] = 0;
        m_ptr = (m_win + 1) % N;
      end else begin
        m_en = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_rdy[i]) begin
          m_v[i]    = 1;
          m_idx[i]  = int'(req_idx[i*IW +: IW]);
          m_phys[i] = int'(req_phys_rd[i*PW +: PW]);
          m_res[i]  = req_result[i*32 +: 32];
        end
      end
    end
  endtask

  task automatic step();
    model_pre();
    @(negedge clk);
    rdy_smp = req_ready;
    chk("req_ready", 64'(rdy_smp), 64'(m_rdy));
    @(posedge clk);
    model_edge();
    #1;
    chk("complete_en", 64'(complete_en), 64'(m_en));
    chk("complete_idx", 64'(complete_idx), 64'(m_oidx));
    chk("complete_result", 64'(complete_result), 64'(m_ores));
    chk("wake_phys_rd", 64'(wake_phys_rd), 64'(m_ophys));
    chk("grant_src", 64'(grant_src), 64'(m_src));
`ifdef CMPL_ARB_PERF_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
  endtask

  // Unit i gets idx=base+i, phys=base+i+7, result=0xDEADBEEA+base+i.
  task automatic set_data(input int base);
    for (int i = 0; i < N; i++) begin
      req_idx[i*IW +: IW]     = IW'(base + i);
      req_phys_rd[i*PW +: PW] = PW'(base + i + 7);
      req_result[i*32 +: 32]  = 32'hDEADBEEA + 32'(base + i);
    end
  endtask

  typedef struct {
    bit           rst;
    bit           flush;
    logic [N-1:0] valid;
    int           base;
    logic [N-1:0] e_rdy;
    bit           e_en;
    int           e_idx;
    int           e_src;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit f, input logic [N-1:0] v, input int b,
                     input logic [N-1:0] er, input bit ee, input int ei, input int es);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.base = b;
    t.e_rdy = er; t.e_en = ee; t.e_idx = ei; t.e_src = es;
    tbl.push_back(t);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    req_idx = '0; req_phys_rd = '0; req_result = '0;

    //  rst flush valid base  ready  en idx src
    add(1, 0, 3'b000, 0,  3'b000, 0, 0,  0);  // 0  reset
    add(0, 0, 3'b010, 4,  3'b111, 0, 0,  0);  // 1  unit1 idx5
    add(0, 0, 3'b000, 0,  3'b111, 1, 5,  1);  // 2  completes two cycles later
    add(0, 0, 3'b000, 0,  3'b111, 0, 5,  1);  // 3
    add(1, 0, 3'b111, 0,  3'b000, 0, 0,  0);  // 4  reset: rr back to 0
    add(0, 0, 3'b111, 0,  3'b111, 0, 0,  0);  // 5  full contention
    add(0, 0, 3'b111, 3,  3'b001, 1, 0,  0);  // 6
    add(0, 0, 3'b111, 6,  3'b010, 1, 1,  1);  // 7
    add(0, 0, 3'b111, 9,  3'b100, 1, 2,  2);  // 8
    add(0, 0, 3'b111, 12, 3'b001, 1, 3,  0);  // 9
    add(0, 0, 3'b000, 0,  3'b010, 1, 7,  1);  // 10 drain
    add(0, 0, 3'b000, 0,  3'b110, 1, 11, 2);  // 11
    add(0, 0, 3'b000, 0,  3'b111, 1, 12, 0);  // 12
    add(0, 0, 3'b000, 0,  3'b111, 0, 12, 0);  // 13
    add(0, 0, 3'b100, 1,  3'b111, 0, 12, 0);  // 14 unit2 back-to-back idx 3,4,5
    add(0, 0, 3'b100, 2,  3'b111, 1, 3,  2);  // 15
    add(0, 0, 3'b100, 3,  3'b111, 1, 4,  2);  // 16
    add(0, 0, 3'b000, 0,  3'b111, 1, 5,  2);  // 17
    add(0, 0, 3'b000, 0,  3'b111, 0, 5,  2);  // 18
    add(0, 0, 3'b101, 8,  3'b111, 0, 5,  2);  // 19 units 0,2 load
    add(0, 1, 3'b000, 0,  3'b000, 0, 5,  2);  // 20 flush
    add(0, 0, 3'b000, 0,  3'b111, 0, 5,  2);  // 21
    add(0, 0, 3'b001, 9,  3'b111, 0, 5,  2);  // 22 new unit0 request
    add(0, 0, 3'b000, 0,  3'b111, 1, 9,  0);  // 23
    add(0, 0, 3'b000, 0,  3'b111, 0, 9,  0);  // 24
    add(0, 0, 3'b111, 0,  3'b111, 0, 9,  0);  // 25 fill all slots
    add(0, 0, 3'b000, 0,  3'b010, 1, 1,  1);  // 26
    add(1, 0, 3'b000, 0,  3'b000, 0, 0,  0);  // 27 reset mid-stream
    add(0, 0, 3'b000, 0,  3'b111, 0, 0,  0);  // 28

    for (int r = 0; r < tbl.size(); r++) begin
`ifdef CMPL_ARB_PERF_EN
      logic [15:0] cnt_before;
      cnt_before = conflict_cnt;
`endif
      rst = tbl[r].rst; flush = tbl[r].flush; req_valid = tbl[r].valid;
      set_data(tbl[r].base);
      step();
      chk($sformatf("tbl%0d_ready", r), 64'(rdy_smp), 64'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_en", r), 64'(complete_en), 64'(tbl[r].e_en));
      chk($sformatf("tbl%0d_idx", r), 64'(complete_idx), 64'(tbl[r].e_idx));
      chk($sformatf("tbl%0d_src", r), 64'(grant_src), 64'(tbl[r].e_src));
      if (r == 2) begin
        chk("single_result", 64'(complete_result), 64'h0000_0000_DEAD_BEEF);
        chk("single_wake", 64'(wake_phys_rd), 64'd12);
      end
`ifdef CMPL_ARB_PERF_EN
      if (tbl[r].flush) chk("flush_keeps_cnt", 64'(conflict_cnt), 64'(cnt_before));
`endif
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      req_valid = N'($urandom) | N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_idx[i*IW +: IW]     = IW'($urandom);
        req_phys_rd[i*PW +: PW] = PW'($urandom);
        req_result[i*32 +: 32]  = $urandom;
      end
      step();
    end

`ifdef CMPL_ARB_PERF_EN
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    step();
    rst = 1'b0; req_valid = 3'b011; set_data(0);
    step();
    for (int c = 0; c < 10; c++) step();
    chk("perf_ten_conflicts", 64'(conflict_cnt), 64'd10);
    for (int c = 0; c < 65530; c++) step();
    chk("perf_saturated", 64'(conflict_cnt), 64'hFFFF);
    for (int c = 0; c < 5; c++) step();
    chk("perf_stays_saturated", 64'(conflict_cnt), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_complete_arb.md
# rob_complete_arb

Completion arbiter between the execution units and the reorder buffer's single completion port. Each execution unit (ALU, MUL, LSU, …) hands its finished result to a one-entry holding slot. A round-robin arbiter then forwards one slot per cycle through a registered output stage. That output drives the ROB complete port and broadcasts the physical destination tag for issue-queue wakeup. On a misprediction flush, all buffered completions are discarded.

## Interface
- NUM_REQ, 3, number of completing execution units (2..8)
- ROB_IDX_BITS, 4, ROB index width
- PHYS_REG_BITS, 6, physical register tag width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  misprediction flush; discards held and output-stage entries
- req_valid  input  NUM_REQ  unit i has a completion
- req_ready  output  NUM_REQ  slot i accepts this cycle
- req_idx  input  NUM_REQ*ROB_IDX_BITS  ROB index, unit i in bits [i*ROB_IDX_BITS +: ROB_IDX_BITS]
- req_phys_rd  input  NUM_REQ*PHYS_REG_BITS  physical dest tag, packed likewise
- req_result  input  NUM_REQ*32  result, packed likewise
- complete_en  output  1  ROB completion strobe (registered)
- complete_idx  output  ROB_IDX_BITS  ROB index to mark done
- complete_result  output  32  result to write into the ROB
- wake_phys_rd  output  PHYS_REG_BITS  tag broadcast, valid when complete_en=1
- grant_src  output  $clog2(NUM_REQ)  source unit of the current output (debug)
- conflict_cnt  output  16  only with CMPL_ARB_PERF_EN (see Configuration)

## Operation
- Per-unit state: hold_valid[i], plus hold_idx, hold_phys and hold_result.
- Global state: rr_ptr (0..NUM_REQ-1) and the registered output stage.
- Acceptance:
  - req_ready[i] = !hold_valid[i] || grant[i], and is forced to 0 while flush or rst is high.
  - On req_valid[i] && req_ready[i], slot i loads the request and sets hold_valid[i].
- Arbitration (combinational over hold_valid only, never over req_valid):
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first set slot wins and asserts grant[i].
  - With no slot set, there is no grant.
- On a grant to slot i:
  - The output stage loads complete_en=1, idx, result, phys tag and grant_src=i.
  - hold_valid[i] clears, unless a new request into slot i is accepted in the same cycle, in which case the slot reloads.
  - rr_ptr <= (i+1) mod NUM_REQ.
- With no grant: complete_en <= 0 and the other output fields hold their values. rr_ptr holds.
- Flush:
  - Same edge: all hold_valid <= 0 and complete_en <= 0.
  - rr_ptr is kept.
  - Requests presented during the flush cycle are dropped.
- rst: all hold_valid=0, rr_ptr=0, complete_en=0, complete_idx=0, complete_result=0, wake_phys_rd=0, grant_src=0, conflict_cnt=0. rst has priority over flush.
- The block does not check for duplicate ROB indices; that is the producers' responsibility.

## Timing
- Latency: request accepted at edge N → held in cycle N+1 → granted in cycle N+1 at the earliest → complete_en high in cycle N+2.
- Throughput: one completion per cycle overall. Each unit sustains one per cycle while it keeps winning, because of the grant-bypass term in req_ready.
- No combinational path from req_valid to req_ready or to any output.
- Fairness: with all NUM_REQ slots continuously valid, each unit is granted exactly once per NUM_REQ cycles.
- Output-stage reset values: complete_en=0, wake_phys_rd=0.
- Reset mid-operation: held entries are lost and complete_en is low the cycle after the rst edge.

## Configuration
- CMPL_ARB_PERF_EN defined:
  - conflict_cnt is a 16-bit saturating counter.
  - It increments by 1 on each cycle where a grant occurs and at least one other hold_valid is also set.
  - It saturates at 0xFFFF and is cleared by rst only (not by flush).
- Undefined: the conflict_cnt port and its logic are absent.

## Test plan
- Single request: unit 1 sends idx=5, result=0xDEADBEEF, phys=12 at cycle 0 → cycle 2 shows complete_en=1, idx=5, result=0xDEADBEEF, wake=12, grant_src=1; complete_en=0 in cycle 3.
- Full contention: all 3 units valid every cycle from reset, with rr_ptr=0 → grant_src sequence 0,1,2,0,1,2…; req_ready stays high for each unit only in its granted cycle.
- Back-to-back from one unit: unit 2 alone sends idx 3,4,5 on consecutive cycles → complete_idx 3,4,5 on consecutive cycles with no bubbles.
- Flush: units 0 and 2 hold entries, flush pulses for 1 cycle → complete_en stays 0 for 2 cycles; a new unit-0 request afterwards completes normally. With CMPL_ARB_PERF_EN, conflict_cnt is unchanged by the flush.
- Reset mid-stream: rst asserted while slots hold entries and complete_en=1 → next cycle all outputs are at their reset values and req_ready is all-ones after rst drops.
- Perf counter (CMPL_ARB_PERF_EN): 2 units valid for 10 cycles → conflict_cnt=10. After forcing 0xFFFF, further conflicts leave it at 0xFFFF.
